// File: rtl/thunderbolt_time_sync.sv
// Disciplines a local HH:MM:SS clock from a GPS receiver's PPS edge and the
// timing packet that describes the second just passed.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module thunderbolt_time_sync #(
  parameter int TIMEOUT_CYCLES = 12000000,
  parameter int LOCK_COUNT     = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic                   i_pps_raw,
  input  logic                   i_thunder_packet_dv,
  input  logic [`DATA_WIDTH-1:0] i_thunder_hour,
  input  logic [`DATA_WIDTH-1:0] i_thunder_minutes,
  input  logic [`DATA_WIDTH-1:0] i_thunder_seconds,
  output logic                   o_load,
  output logic [`DATA_WIDTH-1:0] o_hour,
  output logic [`DATA_WIDTH-1:0] o_minutes,
  output logic [`DATA_WIDTH-1:0] o_seconds,
  output logic                   o_locked,
  output logic                   o_err,
  output logic [`DATA_WIDTH-1:0] o_load_count
);

  localparam int DW = `DATA_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_MAX     = LW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, WAIT_PKT, WAIT_PPS, LOAD} state_t;
  state_t state;

  logic          pps_meta, pps_sync, pps_prev, pps_armed, pps_evt;
  logic [1:0]    pps_fill;
  logic [DW-1:0] cap_hour, cap_minutes, cap_seconds;
  logic [DW-1:0] next_hour, next_minutes, next_seconds;
  logic          sec_wrap, min_wrap, day_wrap, pkt_valid;
  logic [TW-1:0] timer;
  logic [LW-1:0] lock_cnt, lock_inc;

  // Edges only count once a real low has been synchronized, so a PPS that is
  // already high when reset releases never produces an event.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pps_meta  <= 1'b0;
      pps_sync  <= 1'b0;
      pps_prev  <= 1'b0;
      pps_fill  <= 2'b00;
      pps_armed <= 1'b0;
      pps_evt   <= 1'b0;
    end else begin
      pps_meta  <= i_pps_raw;
      pps_sync  <= pps_meta;
      pps_prev  <= pps_sync;
      pps_fill  <= {pps_fill[0], 1'b1};
      pps_armed <= pps_armed | (pps_fill[1] & ~pps_sync);
      pps_evt   <= pps_armed & pps_sync & ~pps_prev;
    end
  end

  always_comb begin
    pkt_valid    = (i_thunder_hour <= DW'(23)) && (i_thunder_minutes <= DW'(59)) &&
                   (i_thunder_seconds <= DW'(60));
    sec_wrap     = cap_seconds >= DW'(59);
    min_wrap     = sec_wrap && (cap_minutes == DW'(59));
    day_wrap     = min_wrap && (cap_hour == DW'(23));
    next_seconds = sec_wrap ? '0 : cap_seconds + DW'(1);
    next_minutes = min_wrap ? '0 : (sec_wrap ? cap_minutes + DW'(1) : cap_minutes);
    next_hour    = min_wrap ? cap_hour + DW'(1) : cap_hour;
    lock_inc     = lock_cnt + LW'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      o_load       <= 1'b0;
      o_err        <= 1'b0;
      o_locked     <= 1'b0;
      o_hour       <= '0;
      o_minutes    <= '0;
      o_seconds    <= '0;
      o_load_count <= '0;
      cap_hour     <= '0;
      cap_minutes  <= '0;
      cap_seconds  <= '0;
      timer        <= '0;
      lock_cnt     <= '0;
    end else begin
      o_load <= 1'b0;
      o_err  <= 1'b0;
      if (!i_enable) begin
        state    <= IDLE;
        lock_cnt <= '0;
        o_locked <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= WAIT_PKT;
          // A PPS arriving with no packet pending is a missed packet, even if
          // the packet shows up in that very cycle; the packet is still kept.
          WAIT_PKT: begin
            if (pps_evt) begin
              o_err    <= 1'b1;
              lock_cnt <= '0;
              o_locked <= 1'b0;
            end
            if (i_thunder_packet_dv) begin
              if (pkt_valid) begin
                cap_hour    <= i_thunder_hour;
                cap_minutes <= i_thunder_minutes;
                cap_seconds <= i_thunder_seconds;
                timer       <= '0;
                state       <= WAIT_PPS;
              end else begin
                o_err <= 1'b1;
              end
            end
          end
          WAIT_PPS: begin
            if (pps_evt) begin
              state <= LOAD;
              if (!day_wrap) begin
                o_load    <= 1'b1;
                o_hour    <= next_hour;
                o_minutes <= next_minutes;
                o_seconds <= next_seconds;
                if (o_load_count != '1) o_load_count <= o_load_count + DW'(1);
                if (lock_cnt != LOCK_MAX) begin
                  lock_cnt <= lock_inc;
                  o_locked <= (lock_inc == LOCK_MAX);
                end
              end
            end else if (i_thunder_packet_dv && pkt_valid) begin
              cap_hour    <= i_thunder_hour;
              cap_minutes <= i_thunder_minutes;
              cap_seconds <= i_thunder_seconds;
              timer       <= '0;
            end else if (timer == TIMEOUT_LAST) begin
              o_err    <= 1'b1;
              lock_cnt <= '0;
              o_locked <= 1'b0;
              state    <= WAIT_PKT;
            end else begin
              timer <= timer + TW'(1);
              if (i_thunder_packet_dv) o_err <= 1'b1;
            end
          end
          LOAD:    state <= WAIT_PKT;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_thunderbolt_time_sync.sv
// Bench for thunderbolt_time_sync: directed scenarios plus randomized
// packet/PPS traffic checked against a seconds-of-day reference model.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_thunderbolt_time_sync;

  localparam int DW      = `DATA_WIDTH;
  localparam int TIMEOUT = 100;
  localparam int LOCKN   = 3;
  localparam int CNT_MAX = (1 << DW) - 1;

  logic          i_clk = 1'b0;
  logic          i_rst, i_enable, i_pps_raw, i_thunder_packet_dv;
  logic [DW-1:0] i_thunder_hour, i_thunder_minutes, i_thunder_seconds;
  logic          o_load, o_locked, o_err;
  logic [DW-1:0] o_hour, o_minutes, o_seconds, o_load_count;

  int checks = 0, failures = 0;
  int cyc = 0, load_n = 0, err_n = 0, load_cyc = -1, err_cyc = -1;
  int last_pkt_cyc = 0;
  int exp_load = 0, exp_err = 0;
  int m_hour = 0, m_min = 0, m_sec = 0, m_count = 0, m_lock = 0;
  int m_cap_h = 0, m_cap_m = 0, m_cap_s = 0;
  bit m_armed = 0;

  thunderbolt_time_sync #(.TIMEOUT_CYCLES(TIMEOUT), .LOCK_COUNT(LOCKN)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_pps_raw(i_pps_raw),
    .i_thunder_packet_dv(i_thunder_packet_dv), .i_thunder_hour(i_thunder_hour),
    .i_thunder_minutes(i_thunder_minutes), .i_thunder_seconds(i_thunder_seconds),
    .o_load(o_load), .o_hour(o_hour), .o_minutes(o_minutes), .o_seconds(o_seconds),
    .o_locked(o_locked), .o_err(o_err), .o_load_count(o_load_count)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Pulse monitor: counts load/err pulses and remembers when they occurred.
  always @(negedge i_clk) begin
    if (o_load) begin load_n++; load_cyc = cyc; end
    if (o_err)  begin err_n++;  err_cyc  = cyc; end
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".loads"},  load_n,       exp_load);
    checkOutput({tag, ".errs"},   err_n,        exp_err);
    checkOutput({tag, ".hour"},   o_hour,       m_hour);
    checkOutput({tag, ".min"},    o_minutes,    m_min);
    checkOutput({tag, ".sec"},    o_seconds,    m_sec);
    checkOutput({tag, ".count"},  o_load_count, m_count);
    checkOutput({tag, ".locked"}, o_locked,     (m_lock == LOCKN) ? 1 : 0);
  endtask

  function automatic void modelPacket(input int h, input int m, input int s);
    if (h > 23 || m > 59 || s > 60) exp_err++;
    else begin m_cap_h = h; m_cap_m = m; m_cap_s = s; m_armed = 1; end
  endfunction

  // Next second computed as seconds-of-day; a leap second 60 behaves like 59.
  function automatic bit modelPps();
    int t;
    if (!m_armed) begin exp_err++; m_lock = 0; return 0; end
    m_armed = 0;
    t = m_cap_h * 3600 + m_cap_m * 60 + ((m_cap_s > 59) ? 59 : m_cap_s) + 1;
    if (t >= 86400) return 0;
    m_hour = t / 3600; m_min = (t / 60) % 60; m_sec = t % 60;
    m_count = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
    m_lock  = (m_lock < LOCKN) ? m_lock + 1 : LOCKN;
    exp_load++;
    return 1;
  endfunction

  task automatic applyStimulus(input int h, input int m, input int s);
    @(negedge i_clk);
    i_thunder_hour = DW'(h); i_thunder_minutes = DW'(m); i_thunder_seconds = DW'(s);
    i_thunder_packet_dv = 1'b1;
    @(negedge i_clk);
    i_thunder_packet_dv = 1'b0;
    last_pkt_cyc = cyc;
    modelPacket(h, m, s);
    @(negedge i_clk);
    checkOutput("pkt.errs", err_n, exp_err);
  endtask

  task automatic applyPps(input string tag);
    int  raise_c;
    bit  expect_load;
    @(negedge i_clk);
    i_pps_raw = 1'b1;
    raise_c = cyc;
    expect_load = modelPps();
    repeat (4) @(negedge i_clk);
    i_pps_raw = 1'b0;
    repeat (6) @(negedge i_clk);
    if (expect_load) checkOutput({tag, ".latency"}, load_cyc - raise_c, 4);
    checkState(tag);
  endtask

  function automatic int randField(input int maxv, input int edgev);
    if ($urandom_range(0, 3) == 0) return edgev;
    return int'($urandom_range(0, maxv));
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e0, enter_c, c, h, m, s;
    i_rst = 1'b1; i_enable = 1'b0; i_pps_raw = 1'b0; i_thunder_packet_dv = 1'b0;
    i_thunder_hour = '0; i_thunder_minutes = '0; i_thunder_seconds = '0;
    repeat (3) @(negedge i_clk);
    checkState("reset");
    checkOutput("reset.load", o_load, 0);
    checkOutput("reset.err", o_err, 0);
    i_rst = 1'b0; i_enable = 1'b1;
    repeat (5) @(negedge i_clk);

    applyStimulus(12, 34, 56); applyPps("basic");
    applyStimulus(1, 2, 3);    applyPps("lock2");
    applyStimulus(5, 6, 7);    applyPps("lock3");
    applyPps("missed");
    applyStimulus(10, 59, 59); applyPps("hour_carry");
    applyStimulus(23, 59, 59); applyPps("day_roll");
    applyStimulus(24, 0, 0);
    applyStimulus(8, 0, 60);   applyPps("leap");
    applyStimulus(3, 3, 3);
    applyStimulus(4, 4, 4);    applyPps("newest");

    // PPS event and packet arrive together while waiting for a packet.
    @(negedge i_clk);
    i_pps_raw = 1'b1;
    repeat (3) @(negedge i_clk);
    i_thunder_hour = DW'(6); i_thunder_minutes = DW'(30); i_thunder_seconds = DW'(0);
    i_thunder_packet_dv = 1'b1;
    @(negedge i_clk);
    i_thunder_packet_dv = 1'b0;
    void'(modelPps());
    modelPacket(6, 30, 0);
    repeat (2) @(negedge i_clk);
    i_pps_raw = 1'b0;
    repeat (6) @(negedge i_clk);
    checkState("simul");
    applyPps("simul_load");

    applyStimulus(9, 9, 9);
    enter_c = last_pkt_cyc;
    e0 = err_n;
    for (int i = 0; i < 150 && err_n == e0; i++) @(negedge i_clk);
    if (err_n == e0) checkOutput("timeout.seen", 0, 1);
    else checkOutput("timeout.cycles", err_cyc - enter_c, TIMEOUT);
    exp_err++; m_lock = 0; m_armed = 0;
    applyPps("after_timeout");

    applyStimulus(2, 0, 0); applyPps("relock");
    applyStimulus(7, 7, 7);
    i_enable = 1'b0;
    modelPacket(0, 0, 0); m_armed = 0; m_lock = 0;
    repeat (3) @(negedge i_clk);
    checkOutput("disable.locked", o_locked, 0);
    i_enable = 1'b1;
    repeat (2) @(negedge i_clk);
    applyPps("after_disable");

    // Async reset while waiting for PPS with the raw PPS line already high.
    applyStimulus(15, 15, 15);
    @(negedge i_clk);
    i_pps_raw = 1'b1;
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1 checkOutput("async_reset", {o_load, o_err, o_locked, o_hour, o_minutes, o_seconds, o_load_count}, 0);
    repeat (3) @(negedge i_clk);
    #2 i_rst = 1'b0;
    m_hour = 0; m_min = 0; m_sec = 0; m_count = 0; m_lock = 0; m_armed = 0;
    repeat (20) @(negedge i_clk);
    checkState("post_reset");
    i_pps_raw = 1'b0;
    repeat (6) @(negedge i_clk);
    applyStimulus(20, 0, 0); applyPps("fresh_pps");

    for (int it = 0; it < 450; it++) begin
      c = $urandom_range(0, 9);
      if ($urandom_range(0, 5) == 0) begin
        h = randField(23, 23); m = randField(59, 59); s = randField(60, 60);
        case ($urandom_range(0, 2))
          0:       h = $urandom_range(24, CNT_MAX);
          1:       m = $urandom_range(60, CNT_MAX);
          default: s = $urandom_range(61, CNT_MAX);
        endcase
        applyStimulus(h, m, s);
      end
      if (c >= 1) applyStimulus(randField(23, 23), randField(59, 59), randField(60, 59));
      if (c >= 8) applyStimulus(randField(23, 23), randField(59, 59), randField(60, 60));
      applyPps("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
